// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NUM_CH show-ahead FIFOs into one valid/ready stream,
// up to BURST_MAX words per grant, with burst completion reporting.
module fifo_drain_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int BURST_MAX  = 16
) (
  input  logic                         rdclk,
  input  logic                         PresetFull,
  input  logic                         clear,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic [NUM_CH-1:0]            rdempty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] q,
  output logic [NUM_CH-1:0]            rdreq,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NUM_CH)-1:0]    out_chan,
  output logic                         out_last,
  output logic                         burst_done,
  output logic [8:0]                   burst_len
);

  localparam int CH_W = $clog2(NUM_CH);

  // IDLE: wait for work | ARB: pick next channel | BURST: stream granted FIFO
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_BURST} state_t;

  state_t          r_state, w_state_nxt;
  logic [CH_W-1:0] r_grant, w_grant_nxt;
  logic [CH_W-1:0] r_last_grant, w_last_grant_nxt;
  logic [8:0]      r_cnt, w_cnt_nxt;
  logic [8:0]      r_burst_len, w_burst_len_nxt;
  logic            r_burst_done, w_burst_done_nxt;

  logic [NUM_CH-1:0] w_elig;
  logic              w_arb_found;
  logic [CH_W-1:0]   w_arb_ch;
  logic [CH_W-1:0]   w_idx;
  logic              w_head_empty;
  logic              w_xfer;

  assign w_elig       = ~rdempty & ~ch_mask;
  assign w_head_empty = rdempty[r_grant];
  assign out_data     = q[int'(r_grant) * DATA_WIDTH +: DATA_WIDTH];
  assign out_chan     = r_grant;
  assign burst_done   = r_burst_done;
  assign burst_len    = r_burst_len;

  // Search starts just after the previous winner; the previous winner is checked last.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_ch    = r_last_grant;
    w_idx       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = r_last_grant + CH_W'(i);
      if (!w_arb_found && w_elig[w_idx]) begin
        w_arb_found = 1'b1;
        w_arb_ch    = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_burst_done_nxt = 1'b0;
    w_burst_len_nxt  = r_burst_len;
    out_valid        = 1'b0;
    out_last         = 1'b0;
    rdreq            = '0;
    w_xfer           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable && |w_elig) w_state_nxt = S_ARB;
      end

      S_ARB: begin
        if (enable && w_arb_found) begin
          w_grant_nxt = w_arb_ch;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BURST;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_BURST: begin
        out_valid      = ~w_head_empty;
        out_last       = out_valid && (r_cnt == 9'(BURST_MAX - 1));
        w_xfer         = out_valid && out_ready;
        rdreq[r_grant] = w_xfer && !clear;
        if (w_head_empty) begin
          // An empty head with nothing moved yet is a race, not a burst.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          if (r_cnt != '0) begin
            w_burst_done_nxt = 1'b1;
            w_burst_len_nxt  = r_cnt;
            w_last_grant_nxt = r_grant;
          end
        end else if (w_xfer) begin
          if (out_last) begin
            w_state_nxt      = S_IDLE;
            w_cnt_nxt        = '0;
            w_burst_done_nxt = 1'b1;
            w_burst_len_nxt  = 9'(BURST_MAX);
            w_last_grant_nxt = r_grant;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    if (clear) begin
      w_state_nxt      = S_IDLE;
      w_cnt_nxt        = '0;
      w_grant_nxt      = r_grant;
      w_last_grant_nxt = r_last_grant;
      w_burst_done_nxt = 1'b0;
      w_burst_len_nxt  = r_burst_len;
    end
  end

  always_ff @(posedge rdclk or posedge PresetFull) begin
    if (PresetFull) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge rdclk or posedge PresetFull) begin
    if (PresetFull) begin
      r_grant      <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_cnt        <= '0;
      r_burst_done <= 1'b0;
      r_burst_len  <= '0;
    end else begin
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      r_burst_done <= w_burst_done_nxt;
      r_burst_len  <= w_burst_len_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Scoreboard bench for fifo_drain_arbiter: modelled FIFOs feed the DUT, expected
// words and burst records are queued as stimulus is loaded and checked on output.
module tb_fifo_drain_arbiter;

  localparam int DW   = 8;
  localparam int NCH  = 4;
  localparam int BMAX = 16;

  logic              rdclk = 1'b0;
  logic              PresetFull, clear, enable, out_ready;
  logic [NCH-1:0]    ch_mask;
  logic [NCH-1:0]    rdempty = '1;
  logic [NCH*DW-1:0] q = '0;
  logic [NCH-1:0]    rdreq;
  logic [DW-1:0]     out_data;
  logic              out_valid, out_last, burst_done;
  logic [1:0]        out_chan;
  logic [8:0]        burst_len;

  always #5 rdclk = ~rdclk;

  fifo_drain_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BURST_MAX(BMAX)) dut (
    .rdclk(rdclk), .PresetFull(PresetFull), .clear(clear), .enable(enable),
    .ch_mask(ch_mask), .rdempty(rdempty), .q(q), .rdreq(rdreq),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .out_last(out_last), .burst_done(burst_done),
    .burst_len(burst_len)
  );

  typedef struct packed {logic [1:0] chan; logic [7:0] data; logic last;} word_t;
  typedef struct packed {logic [1:0] chan; logic [8:0] len;} burst_t;

  word_t      exp_q[$];
  burst_t     blen_q[$];
  logic [7:0] fq[NCH][$];
  logic [NCH-1:0] pop_mask = '0;
  word_t      mon_w;
  burst_t     mon_b;
  logic [7:0] junk;
  int checks = 0;
  int errors = 0;

  // FIFO model: pop what the DUT requested, then present new heads.
  always begin
    @(posedge rdclk);
    #1;
    for (int i = 0; i < NCH; i++)
      if (pop_mask[i] && fq[i].size() > 0) junk = fq[i].pop_front();
    #1;
    for (int i = 0; i < NCH; i++) begin
      rdempty[i]      = (fq[i].size() == 0);
      q[i*DW +: DW]   = (fq[i].size() == 0) ? 8'h00 : fq[i][0];
    end
  end

  always @(negedge rdclk) begin
    pop_mask = PresetFull ? '0 : rdreq;
    if (!PresetFull) begin
      if (out_valid && out_ready && !clear) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: got chan=%0d data=%h, want no transfer", out_chan, out_data);
        end else begin
          mon_w = exp_q.pop_front();
          if (out_chan !== mon_w.chan || out_data !== mon_w.data || out_last !== mon_w.last) begin
            errors++;
            $display("FAIL xfer_word: got chan=%0d data=%h last=%b, want chan=%0d data=%h last=%b",
                     out_chan, out_data, out_last, mon_w.chan, mon_w.data, mon_w.last);
          end
        end
        checks++;
        if (rdreq !== (4'b0001 << out_chan)) begin
          errors++;
          $display("FAIL rdreq_onehot: got %b, want one-hot of chan %0d", rdreq, out_chan);
        end
      end else begin
        checks++;
        if (rdreq !== '0) begin
          errors++;
          $display("FAIL rdreq_idle: got %b want 0000", rdreq);
        end
      end
      if (burst_done) begin
        checks++;
        if (blen_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got burst_done with len=%0d, want none", burst_len);
        end else begin
          mon_b = blen_q.pop_front();
          if (burst_len !== mon_b.len || out_chan !== mon_b.chan) begin
            errors++;
            $display("FAIL burst_record: got chan=%0d len=%0d, want chan=%0d len=%0d",
                     out_chan, burst_len, mon_b.chan, mon_b.len);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    PresetFull = 1'b1; clear = 1'b0; enable = 1'b1; out_ready = 1'b1; ch_mask = '0;
    exp_q.delete(); blen_q.delete();
    for (int i = 0; i < NCH; i++) fq[i].delete();
    repeat (3) @(posedge rdclk);
    #1 PresetFull = 1'b0;
  endtask

  task automatic load_ch(input int ch, input int first, input int n);
    for (int k = first; k < first + n; k++) fq[ch].push_back(8'(ch*32 + k));
  endtask

  task automatic push_exp(input int ch, input int first, input int n, input int last_at);
    for (int k = first; k < first + n; k++)
      exp_q.push_back('{chan: 2'(ch), data: 8'(ch*32 + k), last: (k == last_at)});
  endtask

  task automatic push_burst(input int ch, input int len);
    blen_q.push_back('{chan: 2'(ch), len: 9'(len)});
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && blen_q.size() == 0) break;
      @(posedge rdclk);
    end
    checks++;
    if (exp_q.size() != 0 || blen_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words and %0d bursts pending, want 0",
               exp_q.size(), blen_q.size());
      exp_q.delete(); blen_q.delete();
    end
    @(posedge rdclk);
    #1;
  endtask

  task automatic test_reset();
    PresetFull = 1'b1;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (rdreq !== '0) begin errors++; $display("FAIL reset_rdreq: got %b want 0000", rdreq); end
    checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_burst_done: got %b want 0", burst_done); end
    checks++; if (burst_len !== 9'd0) begin errors++; $display("FAIL reset_burst_len: got %0d want 0", burst_len); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_out_chan: got %0d want 0", out_chan); end
    apply_reset();
    repeat (3) @(negedge rdclk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_long_burst();
    apply_reset();
    load_ch(2, 0, 20);
    push_exp(2, 0, 16, 15);
    push_exp(2, 16, 4, -1);
    push_burst(2, 16);
    push_burst(2, 4);
    wait_drain(200);
    checks++;
    if (burst_len !== 9'd4) begin errors++; $display("FAIL long_final_len: got %0d want 4", burst_len); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    load_ch(0, 0, 18);
    for (int c = 1; c < NCH; c++) load_ch(c, 0, 2);
    push_exp(0, 0, 16, 15);
    for (int c = 1; c < NCH; c++) push_exp(c, 0, 2, -1);
    push_exp(0, 16, 2, -1);
    push_burst(0, 16); push_burst(1, 2); push_burst(2, 2); push_burst(3, 2); push_burst(0, 2);
    wait_drain(300);
  endtask

  task automatic test_backpressure();
    logic       held;
    logic [7:0] hd;
    logic [1:0] hc;
    apply_reset();
    out_ready = 1'b0;
    held = 1'b0; hd = '0; hc = '0;
    load_ch(1, 0, 6);
    push_exp(1, 0, 6, -1);
    push_burst(1, 6);
    for (int i = 0; i < 60; i++) begin
      @(negedge rdclk);
      if (held && out_valid) begin
        checks++;
        if (out_data !== hd || out_chan !== hc) begin
          errors++;
          $display("FAIL hold_stable: got chan=%0d data=%h, want chan=%0d data=%h", out_chan, out_data, hc, hd);
        end
      end
      held = out_valid && !out_ready; hd = out_data; hc = out_chan;
      if (exp_q.size() == 0 && blen_q.size() == 0) break;
      @(posedge rdclk);
      #1 out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_mask();
    logic seen;
    apply_reset();
    enable = 1'b0;
    ch_mask = 4'b0001;
    load_ch(0, 0, 3);
    load_ch(1, 0, 3);
    seen = 1'b0;
    repeat (10) begin @(negedge rdclk); if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL disabled_grant: got out_valid=1 want 0"); end
    checks++; if (fq[1].size() != 3) begin errors++; $display("FAIL disabled_pop: got %0d words left want 3", fq[1].size()); end
    @(posedge rdclk); #1;
    push_exp(1, 0, 3, -1);
    push_burst(1, 3);
    enable = 1'b1;
    wait_drain(100);
    seen = 1'b0;
    repeat (10) begin @(negedge rdclk); if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL masked_grant: got out_valid=1 want 0"); end
    checks++; if (fq[0].size() != 3) begin errors++; $display("FAIL masked_pop: got %0d words left want 3", fq[0].size()); end
    @(posedge rdclk); #1;
    push_exp(0, 0, 3, -1);
    push_burst(0, 3);
    ch_mask = '0;
    wait_drain(100);
  endtask

  task automatic test_clear();
    apply_reset();
    load_ch(3, 0, 2);
    push_exp(3, 0, 2, -1);
    push_burst(3, 2);
    wait_drain(100);
    load_ch(0, 0, 10);
    push_exp(0, 0, 5, -1);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge rdclk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL clear_setup: got %0d words pending want 0", exp_q.size()); exp_q.delete(); end
    clear = 1'b1;
    @(negedge rdclk);
    checks++; if (rdreq !== '0) begin errors++; $display("FAIL clear_rdreq: got %b want 0000", rdreq); end
    @(posedge rdclk);
    #1 clear = 1'b0;
    @(negedge rdclk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_idle: got out_valid=%b want 0", out_valid); end
    checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL clear_done: got %b want 0", burst_done); end
    checks++; if (burst_len !== 9'd2) begin errors++; $display("FAIL clear_len: got %0d want 2", burst_len); end
    checks++; if (fq[0].size() != 5) begin errors++; $display("FAIL clear_pop: got %0d words left want 5", fq[0].size()); end
    push_exp(0, 5, 5, -1);
    push_burst(0, 5);
    wait_drain(100);
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    load_ch(0, 0, 3);
    push_exp(0, 0, 3, -1);
    push_burst(0, 3);
    wait_drain(100);
    load_ch(1, 0, 10);
    push_exp(1, 0, 3, -1);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge rdclk);
      #1;
    end
    checks++; if (out_chan !== 2'd1) begin errors++; $display("FAIL mid_chan: got %0d want 1", out_chan); end
    #1 PresetFull = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL arst_out_last: got %b want 0", out_last); end
    checks++; if (rdreq !== '0) begin errors++; $display("FAIL arst_rdreq: got %b want 0000", rdreq); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL arst_out_chan: got %0d want 0", out_chan); end
    checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", burst_done); end
    checks++; if (burst_len !== 9'd0) begin errors++; $display("FAIL arst_len: got %0d want 0", burst_len); end
    exp_q.delete();
    load_ch(0, 10, 2);
    push_exp(0, 10, 2, -1);
    push_exp(1, 3, 7, -1);
    push_burst(0, 2);
    push_burst(1, 7);
    @(posedge rdclk);
    #1 PresetFull = 1'b0;
    wait_drain(200);
  endtask

  initial begin
    PresetFull = 1'b1; clear = 1'b0; enable = 1'b1; out_ready = 1'b1; ch_mask = '0;
    test_reset();
    test_long_burst();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_clear();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
